// File: rtl/contador_multimodo.sv
// contador_multimodo: up/down modulo counter driven by synchronized, debounced buttons
// with load, wrap/saturate modes and a registered wrap flag.
module contador_multimodo #(
   parameter int N          = 4,
   parameter int MAX_VAL    = 2**N-1,
   parameter int DEB_CYCLES = 4
) (
   input  logic         clk,
   input  logic         reset_sw,
   input  logic         increment_btn,
   input  logic         decrement_btn,
   input  logic         load_en,
   input  logic [N-1:0] load_val,
   input  logic         sat_mode,
   output logic [N-1:0] contador,
   output logic         at_max,
   output logic         at_min,
   output logic         wrap_pulse
);
   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [N-1:0] MAXV = N'(MAX_VAL);

   logic [1:0]         s1_q, s2_q, deb_q, deb_prev_q, arm_q, prime_q, step;
   logic [1:0][CW-1:0] cnt_q;
   logic [N-1:0]       contador_q, contador_d;
   logic               wrap_q, wrap_d, up, dn;

   // A button only arms once seen released after reset, so a press held through reset never steps.
   assign step = deb_q & ~deb_prev_q & arm_q;
   assign up   = step[0] & ~step[1];
   assign dn   = step[1] & ~step[0];

   always_ff @(posedge clk or posedge reset_sw)
      if (reset_sw) begin
         s1_q       <= '0;
         s2_q       <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         arm_q      <= '0;
         prime_q    <= '0;
         cnt_q      <= '0;
         contador_q <= '0;
         wrap_q     <= 1'b0;
      end else begin
         s1_q       <= {decrement_btn, increment_btn};
         s2_q       <= s1_q;
         prime_q    <= {prime_q[0], 1'b1};
         deb_prev_q <= deb_q;
         arm_q      <= arm_q | (prime_q[1] ? ~s2_q : 2'b00);
         for (int b = 0; b < 2; b++)
            if (s2_q[b] == deb_q[b]) cnt_q[b] <= '0;
            else if (cnt_q[b] == CW'(DEB_CYCLES - 1)) begin
               deb_q[b] <= s2_q[b];
               cnt_q[b] <= '0;
            end else cnt_q[b] <= cnt_q[b] + CW'(1);
         contador_q <= contador_d;
         wrap_q     <= wrap_d;
      end

   always_comb begin
      contador_d = contador_q;
      wrap_d     = 1'b0;
      if (load_en) contador_d = (load_val > MAXV) ? MAXV : load_val;
      else if (up) begin
         wrap_d     = ~sat_mode & (contador_q == MAXV);
         contador_d = (contador_q != MAXV) ? contador_q + N'(1) : (sat_mode ? MAXV : '0);
      end else if (dn) begin
         wrap_d     = ~sat_mode & (contador_q == '0);
         contador_d = (contador_q != '0) ? contador_q - N'(1) : (sat_mode ? '0 : MAXV);
      end
   end

   assign contador   = contador_q;
   assign at_max     = contador_q == MAXV;
   assign at_min     = contador_q == '0;
   assign wrap_pulse = wrap_q;
endmodule

// File: doc/contador_multimodo.md
CONTADOR_MULTIMODO -- requirements
Module: contador_multimodo

Interface
REQ-001 SHALL have parameter N, default 4: counter width in bits, 2 to 16.
REQ-002 SHALL have parameter MAX_VAL, default 2**N-1: modulo limit; the count range is 0..MAX_VAL, with 1 <= MAX_VAL <= 2**N-1.
REQ-003 SHALL have parameter DEB_CYCLES, default 4: button debounce length in clocks, minimum 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset_sw, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port increment_btn, input, 1 bit: raw, asynchronous increment button.
REQ-007 SHALL have port decrement_btn, input, 1 bit: raw, asynchronous decrement button.
REQ-008 SHALL have port load_en, input, 1 bit: synchronous load strobe.
REQ-009 SHALL have port load_val, input, N bits: value to load.
REQ-010 SHALL have port sat_mode, input, 1 bit: 0 selects wrap mode, 1 selects saturate mode.
REQ-011 SHALL have port contador, output, N bits: the current count.
REQ-012 SHALL have port at_max, output, 1 bit: high while contador == MAX_VAL.
REQ-013 SHALL have port at_min, output, 1 bit: high while contador == 0.
REQ-014 SHALL have port wrap_pulse, output, 1 bit: registered one-cycle flag marking a wrap event.

Function
REQ-015 SHALL pass each button through its own 2-flop synchronizer before any other logic uses it.
REQ-016 SHALL debounce each synchronized button independently:
- debounced state changes only after the synchronized value differs from it for DEB_CYCLES consecutive clocks;
- any shorter disagreement restarts that button's debounce counter.
REQ-017 SHALL generate a one-cycle step pulse per button on a 0->1 transition of its debounced state; a held button produces exactly one step.
REQ-018 SHALL update contador on rising edge DEB_CYCLES+3 after the first edge that samples a clean, held-high button, counting that first edge as edge 1.
REQ-019 SHALL resolve the next count in this priority order:
- load_en high: contador <= min(load_val, MAX_VAL);
- inc step and dec step in the same cycle: no change;
- inc step only: count up;
- dec step only: count down;
- otherwise: hold.
REQ-020 SHALL ignore any step pulses in a cycle where load_en is high.
REQ-021 SHALL, in wrap mode, count up from MAX_VAL to 0 and count down from 0 to MAX_VAL, each time asserting wrap_pulse for exactly the next clock cycle.
REQ-022 SHALL, in saturate mode, hold the count at MAX_VAL on an up step and at 0 on a down step, with wrap_pulse remaining 0.
REQ-023 SHALL keep wrap_pulse at 0 on loads and on every non-wrapping step.
REQ-024 SHALL take a sat_mode change into effect on the next step, without altering contador.
REQ-025 SHALL drive at_max and at_min combinationally from contador, with no added latency.
REQ-026 SHALL never let contador exceed MAX_VAL, including when MAX_VAL < 2**N-1.

Reset
REQ-027 SHALL, while reset_sw is high, asynchronously force contador=0, wrap_pulse=0, all synchronizer flops=0, all debounced states=0 and all debounce counters=0; at_min is then 1 and at_max is 0.
REQ-028 SHALL discard any debounce in progress when reset_sw is asserted mid-operation; a button still held at release needs a fresh 0->1 debounced transition, so it produces no step.
REQ-029 SHALL make its first possible step no earlier than edge DEB_CYCLES+3 after reset_sw deasserts.

Verification (N=4, MAX_VAL=9, DEB_CYCLES=4)
REQ-030 SHALL verify reset and press latency: hold reset_sw high, then release and apply a clean increment press -> contador 0 -> 1 exactly 7 edges after the press is first sampled, with one step only even if held 50 cycles.
REQ-031 SHALL verify glitch rejection: an increment_btn high pulse of 3 cycles -> contador unchanged and no step.
REQ-032 SHALL verify wrap mode: sat_mode=0 at count 9, increment -> contador=0 with wrap_pulse high for 1 cycle; then decrement -> contador=9 with wrap_pulse high for 1 cycle.
REQ-033 SHALL verify saturate mode: sat_mode=1 at 9, increment -> stays 9 with at_max=1 and wrap_pulse=0; at 0, decrement -> stays 0 with at_min=1.
REQ-034 SHALL verify load handling: load_en with load_val=15 -> contador=9; load_val=5 in the same cycle as an inc step -> contador=5; simultaneous inc and dec steps -> no change.
REQ-035 SHALL verify mid-debounce reset: reset_sw pulsed 2 cycles into a held press -> contador=0 and no step after release while the button stays high.
